// File: rtl/led_pwm_modulator.sv
`default_nettype none
// ============================================================================
// Module      : led_pwm_modulator
// Description : Four-channel LED PWM modulator with shared phase counter and
//               synchronized per-channel enables driving registered LEDs.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pwm_modulator #(
    parameter int PRESCALE = 4,
    parameter int PWM_BITS = 4,
    parameter int DUTY0    = 2,
    parameter int DUTY1    = 6,
    parameter int DUTY2    = 10,
    parameter int DUTY3    = 14
) (
    input  logic       clock,
    input  logic       i_reset,
    input  logic [3:0] i_enable,
    output logic [3:0] o_leds
);

    localparam int c_ps_w = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_ps_w-1:0] c_ps_last = c_ps_w'(PRESCALE - 1);
    localparam logic [PWM_BITS:0] c_duty [4] = '{
        (PWM_BITS+1)'(DUTY0),
        (PWM_BITS+1)'(DUTY1),
        (PWM_BITS+1)'(DUTY2),
        (PWM_BITS+1)'(DUTY3)
    };

    logic [c_ps_w-1:0]   r_prescale;
    logic [PWM_BITS-1:0] r_phase;
    logic [3:0]          r_en_meta;
    logic [3:0]          r_en_sync;
    logic [3:0]          r_leds;
    logic                w_step;
    logic [3:0]          w_hit;

    assign w_step = (r_prescale == c_ps_last);

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_prescale <= '0;
        end else if (w_step) begin
            r_prescale <= '0;
        end else begin
            r_prescale <= r_prescale + 1'b1;
        end
    end

    // Phase wraps naturally at 2^PWM_BITS; a full-scale duty therefore never misses.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_phase <= '0;
        end else if (w_step) begin
            r_phase <= r_phase + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_en_meta <= '0;
            r_en_sync <= '0;
        end else begin
            r_en_meta <= i_enable;
            r_en_sync <= r_en_meta;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_chan
        assign w_hit[gi] = ({1'b0, r_phase} < c_duty[gi]);
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            r_leds <= '0;
        end else begin
            r_leds <= r_en_sync & w_hit;
        end
    end

    assign o_leds = r_leds;

endmodule
`default_nettype wire

// File: tb/tb_led_pwm_modulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_pwm_modulator
// Description : Directed self-checking bench; default instance plus an
//               override instance (PRESCALE=1, DUTY0=0, DUTY3=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pwm_modulator;

    logic       clk;
    logic       rst_n;
    logic [3:0] enable;
    logic [3:0] leds_a;
    logic [3:0] leds_b;
    int         edge_cnt;
    int         n_assert;
    int         n_fail;
    int         cnt_a [4];
    int         cnt_b [4];

    led_pwm_modulator dut_a (
        .clock    (clk),
        .i_reset  (rst_n),
        .i_enable (enable),
        .o_leds   (leds_a)
    );

    led_pwm_modulator #(
        .PRESCALE (1),
        .DUTY0    (0),
        .DUTY3    (16)
    ) dut_b (
        .clock    (clk),
        .i_reset  (rst_n),
        .i_enable (enable),
        .o_leds   (leds_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges since the most recent reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_edge(input int n);
        int guard;
        guard = 0;
        while (edge_cnt < n && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (edge_cnt < n) begin
            n_assert++;
            n_fail++;
            $error("FAIL wait_edge_%0d: observed %0d expected %0d", n, edge_cnt, n);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        enable   = 4'b0000;

        #1;
        check("rst_a_start", leds_a, 4'b0000);
        check("rst_b_start", leds_b, 4'b0000);
        #1000;
        check("rst_a_mid", leds_a, 4'b0000);
        #990;
        check("rst_a_end", leds_a, 4'b0000);
        check("rst_b_end", leds_b, 4'b0000);
        check_int("rst_edges", edge_cnt, 0);

        @(negedge clk);
        rst_n = 1'b1;

        wait_edge(200);
        check("idle_a", leds_a, 4'b0000);
        check("idle_b", leds_b, 4'b0000);

        // Enable just before phase 0 of a period so LEDs rise at its start.
        wait_edge(254);
        enable = 4'b1111;
        wait_edge(256);
        check("lat2_a", leds_a, 4'b0000);
        wait_edge(257);
        check("rise_a", leds_a, 4'b1111);
        check("rise_b", leds_b, 4'b1110);
        wait_edge(264);
        check("led0_last_a", leds_a, 4'b1111);
        check("ph7_b", leds_b, 4'b1100);
        wait_edge(265);
        check("led0_off_a", leds_a, 4'b1110);
        wait_edge(281);
        check("led1_off_a", leds_a, 4'b1100);
        wait_edge(297);
        check("led2_off_a", leds_a, 4'b1000);
        wait_edge(313);
        check("led3_off_a", leds_a, 4'b0000);

        for (int c = 0; c < 4; c++) begin
            cnt_a[c] = 0;
            cnt_b[c] = 0;
        end
        wait_edge(320);
        for (int k = 1; k <= 64; k++) begin
            wait_edge(320 + k);
            for (int c = 0; c < 4; c++) begin
                cnt_a[c] += int'(leds_a[c]);
                cnt_b[c] += int'(leds_b[c]);
            end
        end
        check_int("high_a0", cnt_a[0], 8);
        check_int("high_a1", cnt_a[1], 24);
        check_int("high_a2", cnt_a[2], 40);
        check_int("high_a3", cnt_a[3], 56);
        check_int("high_b0", cnt_b[0], 0);
        check_int("high_b1", cnt_b[1], 24);
        check_int("high_b2", cnt_b[2], 40);
        check_int("high_b3", cnt_b[3], 64);

        wait_edge(389);
        enable = 4'b0101;
        wait_edge(391);
        check("dis_lat2_a", leds_a, 4'b1111);
        wait_edge(392);
        check("dis_drop_a", leds_a, 4'b0101);
        wait_edge(393);
        check("dis_led0_a", leds_a, 4'b0100);
        wait_edge(425);
        check("dis_led2_a", leds_a, 4'b0000);
        wait_edge(449);
        check("dis_period_a", leds_a, 4'b0101);

        enable = 4'b1111;
        wait_edge(451);
        check("reen_lat2_a", leds_a, 4'b0101);
        check("reen_lat2_b", leds_b, 4'b0100);
        wait_edge(452);
        check("reen_a", leds_a, 4'b1111);
        check("reen_b", leds_b, 4'b1110);

        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_a", leds_a, 4'b0000);
        check("async_rst_b", leds_b, 4'b0000);
        #20;
        check("rst_hold_a", leds_a, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        wait_edge(2);
        check("post_lat2_a", leds_a, 4'b0000);
        wait_edge(3);
        check("post_rise_a", leds_a, 4'b1111);
        check("post_rise_b", leds_b, 4'b1110);
        wait_edge(9);
        check("post_led0_a", leds_a, 4'b1110);
        check("post_ph8_b", leds_b, 4'b1100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
